// File: rtl/sync_send.sv
// Node-side barrier-sync initiator. It takes a core barrier request, handshakes sync_req/sync_gnt with
// the collector, waits for the sync_hit broadcast and returns barrier_done. An optional timeout aborts.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no barrier outstanding; accepts barrier_req
// REQ      | sync_req raised with latched node ID, waiting for sync_gnt
// WAIT_HIT | request transferred, waiting for the sync_hit broadcast
// DONE     | one-cycle success pulse on barrier_done
module sync_send #(
    parameter int NODE_ID_W = 4,
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NODE_ID_W-1:0] node_id,
    input  logic [TIMEOUT_W-1:0] timeout_cfg,
    input  logic                 barrier_req,
    output logic                 barrier_busy,
    output logic                 barrier_done,
    output logic                 done_err,
    output logic                 sync_req,
    output logic [NODE_ID_W-1:0] sync_node_id,
    input  logic                 sync_gnt,
    input  logic                 sync_hit,
    input  logic                 err_clr,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     barrier_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_HIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t               state;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 outstanding;
    logic                 tmo_term;
    logic                 hit_now;
    logic                 abort;

    assign outstanding = (state == REQ) || (state == WAIT_HIT);
    assign tmo_term    = outstanding && (timeout_cfg != '0) &&
                         (tmo_cnt == timeout_cfg - TIMEOUT_W'(1));
    assign hit_now     = (state == WAIT_HIT) && sync_hit;
    // A hit on the terminal cycle completes the barrier; a grant on it does not.
    assign abort       = tmo_term && !hit_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            barrier_busy <= 1'b0;
            barrier_done <= 1'b0;
            done_err     <= 1'b0;
            sync_req     <= 1'b0;
            sync_node_id <= '0;
            timeout_err  <= 1'b0;
            barrier_cnt  <= '0;
        end else begin
            barrier_done <= 1'b0;
            done_err     <= 1'b0;

            if (outstanding && (tmo_cnt != '1))
                tmo_cnt <= tmo_cnt + 1'b1;

            if (abort)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;

            if (abort) begin
                state        <= IDLE;
                barrier_busy <= 1'b0;
                sync_req     <= 1'b0;
                barrier_done <= 1'b1;
                done_err     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (barrier_req) begin
                            state        <= REQ;
                            barrier_busy <= 1'b1;
                            sync_req     <= 1'b1;
                            sync_node_id <= node_id;
                            tmo_cnt      <= '0;
                        end
                    end
                    REQ: begin
                        if (sync_gnt) begin
                            state    <= WAIT_HIT;
                            sync_req <= 1'b0;
                        end
                    end
                    WAIT_HIT: begin
                        if (sync_hit) begin
                            state        <= DONE;
                            barrier_done <= 1'b1;
                            barrier_cnt  <= barrier_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state        <= IDLE;
                        barrier_busy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
